line_mem_responder: RTL
=======================

# line_mem_responder

Line-granular memory responder for the L1-to-MMU request interface. Accepts 256-bit cache-line read and write requests, serves them from an internal 32-bit-wide synchronous RAM over 8 beats, and returns a one-cycle `done` pulse. It is the memory target that answers the line requests issued by the L1 caches or the MMU, replacing a single-cycle 256-bit RAM with a narrow, BRAM-friendly array.

## Interface
- `DEPTH_WORDS`, 16384: RAM depth in 32-bit words. Must be a power of two and a multiple of 8.
- `ADDR_BASE`, 32'h0000_0000: byte address that maps to RAM word 0. Must be 32-byte aligned.
- `sys_clk` in 1: the single clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_read` in 1: line read request; held high until `done`.
- `req_write` in 1: line write request; held high until `done`.
- `req_addr` in 32: byte address; bits [4:0] ignored, so the line is 32-byte aligned.
- `write_data` in 256: line to write; word i occupies bits [32i+31:32i].
- `done` out 1: one-cycle completion pulse.
- `read_data` out 256: last line read; word i occupies bits [32i+31:32i].
- `range_err` out 1: sticky out-of-range flag. Driven 0 unless the range check is compiled in (see Configuration).

## Operation
- States: IDLE, WBEAT, RBEAT, RTAIL, DONE.
- IDLE:
  - If `req_write`, latch line index and `write_data`, clear beat counter, go to WBEAT.
  - Else if `req_read`, latch line index, go to RBEAT.
  - If both requests are high, write wins; one `done` is issued and the read is dropped.
- Line index: `(req_addr - ADDR_BASE) >> 5`.
- RAM word for beat i: `{line_index, i[2:0]}`.
  - Without the range check, this is taken modulo `DEPTH_WORDS`, so addresses wrap.
- WBEAT:
  - Writes latched word i to RAM on each cycle, i = 0..7 in order.
  - After beat 7, go to DONE.
- RBEAT:
  - Issues RAM read address for beat i on each cycle, i = 0..7.
  - The word issued in the previous cycle is captured into `read_data[32(i-1)+:32]`.
  - After beat 7, go to RTAIL.
- RTAIL: captures word 7, then goes to DONE.
- DONE:
  - `done` = 1 for exactly this cycle, then return to IDLE.
  - The requester must drop its request on the edge ending the DONE cycle.
  - A request still high in the following IDLE cycle is treated as a new request.
- `read_data` is updated only by reads. It is held stable from DONE until the next read's capture begins. Writes leave it unchanged.
- Beat counter is 3 bits and wraps 7→0 on the transition out of the beat state.

## Timing
- Reset values: `done`=0, `read_data`=0, `range_err`=0, state=IDLE, beat counter=0.
- Reset does not clear RAM contents.
- Cycle 0 is the IDLE cycle in which the request is sampled.
  - Write: beats in cycles 1–8, `done` in cycle 9 (latency 9).
  - Read: RAM issues in cycles 1–8, final capture in cycle 9, `done` in cycle 10 (latency 10). `read_data` is complete and valid in cycle 10.
- Back-to-back requests: the next request is sampled earliest in cycle 10 (write) or 11 (read). Minimum throughput is one line per 10 or 11 cycles.
- Requests and `req_addr` changing mid-transaction are ignored, because address and write data are latched at acceptance.
- `rst_n` low mid-transaction:
  - Next cycle is IDLE with `done`=0 and `read_data`=0.
  - Beats already written remain in RAM; the rest are not written.
  - No `done` is emitted for the aborted request.

## Configuration
- `LINE_MEM_RANGE_CHECK_EN` defined:
  - A request is out of range if `req_addr < ADDR_BASE` or `req_addr >= ADDR_BASE + 4*DEPTH_WORDS`.
  - Out-of-range writes modify no RAM word.
  - Out-of-range reads return all-zero `read_data`.
  - Latency and the `done` pulse are unchanged in both cases.
  - `range_err` sets on acceptance of the request and clears only on reset.
- Not defined:
  - No comparison logic; indices wrap modulo `DEPTH_WORDS`.
  - `range_err` is tied 0.

## Test plan
- Write line 0x100 with words 0x11111111·i (i=0..7), then read 0x100 → `done` at cycle 9 for the write and cycle 10 for the read; `read_data[32i+:32]` = 0x11111111·i.
- Both requests high at 0x40, `write_data`=all 0xA5 → exactly one `done` at cycle 9; a subsequent read of 0x40 returns all 0xA5; `read_data` unchanged by the write.
- Write at 0x47 (unaligned), read at 0x40 → same line returned; bits [4:0] are ignored.
- Reset asserted in cycle 4 of a write of 0xDEADBEEF·8 to 0x200 over prior all-zero content → no `done`; outputs 0 the next cycle; read of 0x200 returns words 0–2 = 0xDEADBEEF and words 3–7 = 0.
- Without the macro, `DEPTH_WORDS`=16: write 0x80 (aliases 0x0), read 0x0 → data matches and `range_err`=0. With the macro: write 0x80 → RAM unchanged, `range_err`=1 after acceptance, read 0x80 returns 0.
- Requester holds `req_read` one cycle past `done` → a second read is accepted and a second `done` arrives 10 cycles later.

Source files
------------

// File: rtl/line_mem_responder.sv
// line_mem_responder
//   Line-granular memory target for the L1-to-MMU request interface.
//   A 256-bit cache line is moved to or from a 32-bit-wide synchronous RAM
//   in 8 beats, and the request is completed with a one-cycle done pulse.
//
//   Write: request sampled in cycle 0, beats in cycles 1-8, done in cycle 9.
//   Read : RAM addresses issued in cycles 1-8, last capture in cycle 9,
//          done in cycle 10 with read_data complete.
//
// Parameters
//   DEPTH_WORDS : RAM depth in 32-bit words (power of two, at least 16).
//   ADDR_BASE   : byte address of RAM word 0 (32-byte aligned).
//
// Ports
//   sys_clk    : clock, all logic on the rising edge
//   rst_n      : synchronous active-low reset (RAM contents are kept)
//   req_read   : line read request, held until done
//   req_write  : line write request, held until done (wins over req_read)
//   req_addr   : byte address, bits [4:0] ignored
//   write_data : line to write, word i in bits [32i+31:32i]
//   done       : one-cycle completion pulse
//   read_data  : last line read, word i in bits [32i+31:32i]
//   range_err  : sticky out-of-range flag
//
// Optional feature
//   LINE_MEM_RANGE_CHECK_EN : when defined, requests outside
//   [ADDR_BASE, ADDR_BASE + 4*DEPTH_WORDS) write nothing, read zeros and
//   set range_err until reset. When undefined, line indices wrap modulo the
//   RAM depth and range_err is tied low.

module line_mem_responder #(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    input  logic         req_read,
    input  logic         req_write,
    input  logic [31:0]  req_addr,
    input  logic [255:0] write_data,
    output logic         done,
    output logic [255:0] read_data,
    output logic         range_err
);

    localparam int AW = $clog2(DEPTH_WORDS);  // word address width
    localparam int LW = AW - 3;               // line index width

    typedef enum logic [2:0] {
        IDLE,
        WBEAT,
        RBEAT,
        RTAIL,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [2:0]      beat_q;
    logic [2:0]      cap_idx;
    logic [LW-1:0]   line_q;
    logic [LW-1:0]   line_d;
    logic [255:0]    wline_q;
    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     rword_q;
    logic [AW-1:0]   ram_addr;
    logic            ram_we;
    logic            accept;
    logic            oor_q;
    logic            unused_addr_bits;

    assign accept = req_write | req_read;

    // Base is 32-byte aligned, so subtracting only the line-index bits gives
    // the same result as (req_addr - ADDR_BASE) >> 5 taken modulo the depth.
    assign line_d = req_addr[AW+1:5] - ADDR_BASE[AW+1:5];

    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[4:0]};

    // Word captured this cycle was addressed by the previous beat.
    assign cap_idx  = beat_q - 3'd1;
    assign ram_addr = {line_q, beat_q};

    // rst_n gates the write so a reset cycle never commits its beat.
    assign ram_we = (state_q == WBEAT) && rst_n && !oor_q;

    // ---------------- next-state / outputs ----------------
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_write)     state_d = WBEAT;
                else if (req_read) state_d = RBEAT;
            end
            WBEAT: if (beat_q == 3'd7) state_d = DONE;
            RBEAT: if (beat_q == 3'd7) state_d = RTAIL;
            RTAIL: state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- control registers ----------------
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= 3'd0;
            read_data <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE:  if (accept) beat_q <= 3'd0;
                WBEAT: beat_q <= beat_q + 3'd1;
                RBEAT: begin
                    beat_q <= beat_q + 3'd1;
                    if (beat_q != 3'd0)
                        read_data[{cap_idx, 5'b0} +: 32] <= oor_q ? 32'd0 : rword_q;
                end
                RTAIL: read_data[224 +: 32] <= oor_q ? 32'd0 : rword_q;
                default: ;
            endcase
        end
    end

    // ---------------- request latch ----------------
    always_ff @(posedge sys_clk) begin
        if (state_q == IDLE && accept) line_q <= line_d;
        if (state_q == IDLE && req_write) wline_q <= write_data;
    end

    // ---------------- RAM ----------------
    always_ff @(posedge sys_clk) begin
        if (ram_we) mem[ram_addr] <= wline_q[{beat_q, 5'b0} +: 32];
        rword_q <= mem[ram_addr];
    end

`ifdef LINE_MEM_RANGE_CHECK_EN
    // 33-bit limit so a base near the top of the address space cannot wrap.
    localparam logic [32:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);

    logic oor_d;
    logic range_err_q;

    assign oor_d = (req_addr < ADDR_BASE) || ({1'b0, req_addr} >= ADDR_LIMIT);

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            oor_q       <= 1'b0;
            range_err_q <= 1'b0;
        end else if (state_q == IDLE && accept) begin
            oor_q <= oor_d;
            if (oor_d) range_err_q <= 1'b1;
        end
    end

    assign range_err = range_err_q;
`else
    assign oor_q     = 1'b0;
    assign range_err = 1'b0;
`endif

endmodule
